piezo_melody_seq: RTL and testbench

PIEZO_MELODY_SEQ -- requirements
Module: piezo_melody_seq

---
 rtl/piezo_pkg.sv | 44 ++++
 rtl/piezo_melody_rom.sv | 14 +
 rtl/piezo_melody_seq.sv | 130 +++++++++++++
 tb/tb_piezo_melody_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo melody sequencer: FSM states,
// note indices, ROM entry layout and the default demo melody.
package piezo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_FINISH
    } state_t;

    localparam int NOTE_W    = 3;
    localparam int DUR_W     = 3;
    localparam int ROM_W     = NOTE_W + DUR_W;
    localparam int ROM_DEPTH = 16;
    localparam int IDX_W     = 4;

    localparam logic [NOTE_W-1:0] NOTE_DO  = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_RE  = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_MI  = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_FA  = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_SOL = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_LA  = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_SI  = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_HDO = 3'd7;

    localparam logic [DUR_W-1:0] DUR_END = '0;

    typedef logic [ROM_W-1:0] rom_entry_t;
    typedef rom_entry_t [ROM_DEPTH-1:0] rom_image_t;

    // Entry 0 sits in the least significant slot: DO x2, SOL x1, HDO x1, end.
    localparam rom_image_t DEMO_ROM = rom_image_t'({78'd0,
                                                    NOTE_HDO, 3'd1,
                                                    NOTE_SOL, 3'd1,
                                                    NOTE_DO,  3'd2});

    // DO drives KEY bit 7, high DO drives bit 0.
    function automatic logic [7:0] note_onehot(input logic [NOTE_W-1:0] note);
        return 8'h80 >> note;
    endfunction

endpackage

// File: rtl/piezo_melody_rom.sv
// Combinational 16 x {note, dur} melody lookup addressed by the current note index.
module piezo_melody_rom
    import piezo_pkg::*;
#(
    parameter rom_image_t ROM_INIT = DEMO_ROM
) (
    input  logic [IDX_W-1:0]  addr,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  dur
);

    assign {note, dur} = ROM_INIT[addr];

endmodule

// File: rtl/piezo_melody_seq.sv
// Melody sequencer: steps through the ROM producing a registered one-hot KEY
// select for the tone generator, with a manual keypad pass-through while idle.
module piezo_melody_seq
    import piezo_pkg::*;
#(
    parameter int         BEAT_TICKS = 25000,
    parameter int         GAP_TICKS  = 2500,
    parameter rom_image_t ROM_INIT   = DEMO_ROM
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             STOP,
    input  logic [7:0]       KEY_IN,
    output logic [7:0]       KEY_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [IDX_W-1:0] NOTE_IDX
);

    // Wide enough for the longest note (7 beats) and for the gap length; since
    // 7*BEAT_TICKS is never a power of two the full product also fits.
    localparam int PLAY_MAX = 7 * BEAT_TICKS;
    localparam int CNT_MAX  = (GAP_TICKS > PLAY_MAX) ? GAP_TICKS : PLAY_MAX;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_M1   = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    localparam logic [CNT_W-1:0] BEAT_C   = CNT_W'(BEAT_TICKS);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_M1);

    state_t             state;
    state_t             next_state;
    state_t             advance_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   play_load;
    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;
    logic [7:0]         key_next;
    logic [7:0]         key_filtered;
    logic [IDX_W-1:0]   idx_next;
    logic               cnt_zero;
    logic               last_entry;

    piezo_melody_rom #(
        .ROM_INIT (ROM_INIT)
    ) melody_rom (
        .addr (NOTE_IDX),
        .note (rom_note),
        .dur  (rom_dur)
    );

    assign cnt_zero      = (cnt == '0);
    assign last_entry    = (NOTE_IDX == IDX_W'(ROM_DEPTH - 1));
    assign advance_state = last_entry ? S_FINISH : S_FETCH;
    assign play_load     = CNT_W'(rom_dur) * BEAT_C - CNT_W'(1);
    // Keypad chords and releases both map to silence.
    assign key_filtered  = ((KEY_IN != 8'h00) && ((KEY_IN & (KEY_IN - 8'd1)) == 8'h00))
                           ? KEY_IN : 8'h00;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (START) next_state = S_FETCH;
            S_FETCH:  next_state = (rom_dur == DUR_END) ? S_FINISH : S_PLAY;
            S_PLAY:   if (cnt_zero) next_state = (GAP_TICKS > 0) ? S_GAP : advance_state;
            S_GAP:    if (cnt_zero) next_state = advance_state;
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (STOP) next_state = S_IDLE;
    end

    always_comb begin
        key_next = 8'h00;
        idx_next = NOTE_IDX;
        cnt_next = cnt;
        case (state)
            S_IDLE: begin
                if (next_state == S_IDLE) key_next = key_filtered;
            end
            S_FETCH: begin
                if (next_state == S_PLAY) begin
                    key_next = note_onehot(rom_note);
                    cnt_next = play_load;
                end
            end
            S_PLAY: begin
                if (next_state == S_PLAY) begin
                    key_next = note_onehot(rom_note);
                    cnt_next = cnt - CNT_W'(1);
                end else if (next_state == S_GAP) begin
                    cnt_next = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (next_state == S_GAP) cnt_next = cnt - CNT_W'(1);
            end
            default: ;
        endcase
        if ((next_state == S_FETCH) && ((state == S_PLAY) || (state == S_GAP)))
            idx_next = NOTE_IDX + IDX_W'(1);
        if (next_state == S_IDLE) idx_next = '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            KEY_OUT  <= 8'h00;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            NOTE_IDX <= '0;
            cnt      <= '0;
        end else begin
            KEY_OUT  <= key_next;
            BUSY     <= (next_state != S_IDLE);
            DONE     <= (next_state == S_FINISH);
            NOTE_IDX <= idx_next;
            cnt      <= cnt_next;
        end
    end

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Bench for piezo_melody_seq: a demo-melody instance and a 16-note instance,
// checked cycle by cycle against a timeline built from the melody rules.
module tb_piezo_melody_seq;
    import piezo_pkg::*;

    localparam int BT = 4;
    localparam int GT = 2;

    function automatic rom_image_t make_demo_rom();
        rom_image_t img;
        img    = '0;
        img[0] = {3'd0, 3'd2};
        img[1] = {3'd4, 3'd1};
        img[2] = {3'd7, 3'd1};
        return img;
    endfunction

    function automatic rom_image_t make_full_rom();
        rom_image_t img;
        for (int i = 0; i < 16; i++) img[i] = {3'(i % 8), 3'd1};
        return img;
    endfunction

    localparam rom_image_t TB_DEMO  = make_demo_rom();
    localparam rom_image_t FULL_ROM = make_full_rom();

    logic       clk;
    logic       rst_n;
    logic       start_a, stop_a, start_b, stop_b;
    logic [7:0] key_a, key_b;
    logic [7:0] key_out_a, key_out_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [3:0] idx_a, idx_b;

    int tests = 0;
    int fails = 0;
    logic [13:0] exp_q[$];

    piezo_melody_seq #(.BEAT_TICKS(BT), .GAP_TICKS(GT), .ROM_INIT(TB_DEMO)) dut_a (
        .CLK(clk), .RESETN(rst_n), .START(start_a), .STOP(stop_a), .KEY_IN(key_a),
        .KEY_OUT(key_out_a), .BUSY(busy_a), .DONE(done_a), .NOTE_IDX(idx_a)
    );

    piezo_melody_seq #(.BEAT_TICKS(BT), .GAP_TICKS(GT), .ROM_INIT(FULL_ROM)) dut_b (
        .CLK(clk), .RESETN(rst_n), .START(start_b), .STOP(stop_b), .KEY_IN(key_b),
        .KEY_OUT(key_out_b), .BUSY(busy_b), .DONE(done_b), .NOTE_IDX(idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic [7:0] k, input logic b,
                                       input logic d, input logic [3:0] i);
        return {k, b, d, i};
    endfunction

    function automatic logic [13:0] obs(input bit sel);
        return sel ? {key_out_b, busy_b, done_b, idx_b} : {key_out_a, busy_a, done_a, idx_a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [13:0] o, input logic [13:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got key=%h busy=%b done=%b idx=%0d, want key=%h busy=%b done=%b idx=%0d",
                   tag, o[13:6], o[5], o[4], o[3:0], e[13:6], e[5], e[4], e[3:0]);
        end
    endtask

    // Expected per-cycle outputs from the START edge up to the first idle cycle.
    task automatic build_trace(input rom_image_t img);
        int         idx;
        bit         fin;
        logic [2:0] note, dur;
        exp_q.delete();
        idx = 0;
        fin = 0;
        exp_q.push_back(pk(8'h00, 1'b1, 1'b0, 4'(idx)));
        while (!fin) begin
            {note, dur} = img[idx];
            if (dur == 3'd0) begin
                fin = 1;
            end else begin
                repeat (int'(dur) * BT) exp_q.push_back(pk(8'h80 >> note, 1'b1, 1'b0, 4'(idx)));
                repeat (GT) exp_q.push_back(pk(8'h00, 1'b1, 1'b0, 4'(idx)));
                if (idx == 15) fin = 1;
                else begin
                    idx++;
                    exp_q.push_back(pk(8'h00, 1'b1, 1'b0, 4'(idx)));
                end
            end
        end
        exp_q.push_back(pk(8'h00, 1'b1, 1'b1, 4'(idx)));
        exp_q.push_back(pk(8'h00, 1'b0, 1'b0, 4'd0));
    endtask

    task automatic play(input string tag, input bit sel, input bit hold_start, input bit rand_keys);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (sel) key_b = rand_keys ? 8'($urandom) : 8'h00;
            else     key_a = rand_keys ? ((k % 3 == 0) ? 8'h20 : 8'($urandom)) : 8'h00;
            tick();
            if (!hold_start) begin
                if (sel) start_b = 1'b0; else start_a = 1'b0;
            end
            check(tag, obs(sel), exp_q[k]);
        end
        key_a = 8'h00;
        key_b = 8'h00;
    endtask

    task automatic stop_after(input string tag, input int s);
        start_a = 1'b1;
        for (int k = 0; k < s; k++) begin
            tick();
            start_a = 1'b0;
            key_a   = 8'($urandom);
            check(tag, obs(1'b0), exp_q[k]);
        end
        stop_a = 1'b1;
        tick();
        check({tag, "_stopped"}, obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));
        stop_a = 1'b0;
        key_a  = 8'h00;
        repeat (4) begin
            tick();
            check({tag, "_idle"}, obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));
        end
    endtask

    initial begin
        logic [7:0] kv;
        int         s;
        rst_n   = 1'b0;
        start_a = 1'b1;
        stop_a  = 1'b0;
        start_b = 1'b1;
        stop_b  = 1'b0;
        key_a   = 8'h10;
        key_b   = 8'h10;
        repeat (3) tick();
        check("reset_a", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));
        check("reset_b", obs(1'b1), pk(8'h00, 1'b0, 1'b0, 4'd0));
        start_a = 1'b0;
        start_b = 1'b0;
        key_a   = 8'h00;
        key_b   = 8'h00;
        rst_n   = 1'b1;
        tick();
        check("idle_after_reset", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));

        key_a = 8'h20;
        tick();
        check("keypad_single", obs(1'b0), pk(8'h20, 1'b0, 1'b0, 4'd0));
        key_a = 8'h24;
        tick();
        check("keypad_multi", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));
        for (int i = 0; i < 10; i++) begin
            kv    = (i % 2 == 0) ? (8'h01 << $urandom_range(7, 0)) : 8'($urandom);
            key_a = kv;
            tick();
            check("keypad_rand", obs(1'b0), pk(($countones(kv) == 1) ? kv : 8'h00, 1'b0, 1'b0, 4'd0));
        end
        key_a = 8'h00;
        tick();

        start_a = 1'b1;
        stop_a  = 1'b1;
        repeat (3) begin
            tick();
            check("start_stop_idle", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));
        end
        start_a = 1'b0;
        stop_a  = 1'b0;

        build_trace(TB_DEMO);
        play("demo_pulse", 1'b0, 1'b0, 1'b1);
        tick();
        check("demo_idle", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));

        play("demo_held_1", 1'b0, 1'b1, 1'b1);
        play("demo_held_2", 1'b0, 1'b1, 1'b0);
        start_a = 1'b0;
        tick();
        check("demo_held_idle", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));

        stop_after("stop_third_cycle", 4);
        for (int i = 0; i < 3; i++) begin
            s = $urandom_range(exp_q.size() - 1, 1);
            stop_after("stop_rand", s);
        end

        start_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            start_a = 1'b0;
            check("pre_reset_gap", obs(1'b0), exp_q[k]);
        end
        rst_n = 1'b0;
        key_a = 8'h40;
        tick();
        check("reset_mid_gap", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));
        tick();
        check("reset_hold", obs(1'b0), pk(8'h00, 1'b0, 1'b0, 4'd0));
        rst_n = 1'b1;
        key_a = 8'h00;
        tick();
        play("replay_after_reset", 1'b0, 1'b0, 1'b0);

        build_trace(FULL_ROM);
        play("full_rom", 1'b1, 1'b0, 1'b1);
        repeat (5) begin
            tick();
            check("full_rom_no_wrap", obs(1'b1), pk(8'h00, 1'b0, 1'b0, 4'd0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
